// File: rtl/axis_packet_arbiter.sv
// Two-input AXI-Stream packet arbiter with round-robin contention handling.
// A granted requester owns the output until its packet ends; packets longer than NUMBER_OF_WORDS are split.
module axis_packet_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int NUMBER_OF_WORDS    = 5
) (
  input  logic                            m00_axis_aclk,
  input  logic                            m00_axis_aresetn,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s01_axis_tvalid,
  output logic                            s01_axis_tready,
  input  logic                            s01_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic [1:0]                      grant,
  output logic                            error_len,
  output logic [15:0]                     pkt_count0,
  output logic [15:0]                     pkt_count1
);

  localparam logic [7:0] LAST_BEAT = 8'(NUMBER_OF_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic [7:0] beat_cnt;
  logic       src_last;
  logic       accept;
  logic       pkt_end;

  assign accept  = m00_axis_tvalid & m00_axis_tready;
  assign pkt_end = accept & m00_axis_tlast;

  // last_grant=1 means s01 owned the previous packet, so s00 wins the next tie
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid) state_next = last_grant ? GRANT0 : GRANT1;
        else if (s00_axis_tvalid)               state_next = GRANT0;
        else if (s01_axis_tvalid)               state_next = GRANT1;
      end
      GRANT0, GRANT1: if (pkt_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    src_last        = 1'b0;
    grant           = 2'b00;
    case (state)
      GRANT0: begin
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        s00_axis_tready = m00_axis_tready;
        src_last        = s00_axis_tlast;
        grant           = 2'b01;
      end
      GRANT1: begin
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        s01_axis_tready = m00_axis_tready;
        src_last        = s01_axis_tlast;
        grant           = 2'b10;
      end
      default: ;
    endcase
    m00_axis_tlast = (state != IDLE) && (src_last || (beat_cnt == LAST_BEAT));
  end

  // A forced end (length limit hit without source tlast) latches error_len
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      error_len  <= 1'b0;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      state <= state_next;
      if (pkt_end) begin
        beat_cnt   <= '0;
        last_grant <= (state == GRANT1);
        if (state == GRANT0) pkt_count0 <= pkt_count0 + 16'd1;
        else                 pkt_count1 <= pkt_count1 + 16'd1;
        if (!src_last) error_len <= 1'b1;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized scoreboard bench for axis_packet_arbiter: per-source expected beat queues
// plus a packet-level arbitration model, checked by a negedge monitor.
module tb_axis_packet_arbiter;

  localparam int W = 32;
  localparam int N = 5;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [W/8-1:0] strb;
    logic           last;
    logic           forced;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s00_tvalid, s00_tready, s00_tlast;
  logic [W-1:0]   s00_tdata;
  logic [W/8-1:0] s00_tstrb;
  logic           s01_tvalid, s01_tready, s01_tlast;
  logic [W-1:0]   s01_tdata;
  logic [W/8-1:0] s01_tstrb;
  logic           m_tvalid, m_tready, m_tlast;
  logic [W-1:0]   m_tdata;
  logic [W/8-1:0] m_tstrb;
  logic [1:0]     grant;
  logic           error_len;
  logic [15:0]    pkt_count0, pkt_count1;

  int    checks = 0;
  int    errors = 0;
  beat_t src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
  int    grant_log[$];
  int    acc_cycles[$];
  int    cyc = 0;
  int    rdy_mode = 0;
  bit    gap_en = 0;
  bit    acc0 = 0, acc1 = 0;

  int          m_owner = -1;
  int          m_last = 1;
  logic        m_err = 1'b0;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0;
  beat_t       mon_e;

  axis_packet_arbiter #(.C_AXIS_TDATA_WIDTH(W), .NUMBER_OF_WORDS(N)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready), .s00_axis_tlast(s00_tlast),
    .s00_axis_tdata(s00_tdata), .s00_axis_tstrb(s00_tstrb),
    .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready), .s01_axis_tlast(s01_tlast),
    .s01_axis_tdata(s01_tdata), .s01_axis_tstrb(s01_tstrb),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready), .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .grant(grant), .error_len(error_len), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Output tlast falls on the source tlast or on every N-th beat of the source packet
  task automatic apply_stimulus(input int src, input int len, input logic [31:0] base, input bit rnd);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data   = rnd ? $urandom : base + 32'(i);
      b.strb   = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
      b.last   = (i == len - 1);
      b.forced = 1'b0;
      e        = b;
      e.last   = (i == len - 1) || (i % N == N - 1);
      e.forced = e.last && !b.last;
      if (src == 0) begin src_q0.push_back(b); exp_q0.push_back(e); end
      else          begin src_q1.push_back(b); exp_q1.push_back(e); end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_err   = 1'b0;
    m_cnt0  = '0;
    m_cnt1  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    grant_log.delete();
    acc_cycles.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || exp_q0.size() != 0 ||
            exp_q1.size() != 0 || m_owner >= 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d/%0d beats left required=0", exp_q0.size(), exp_q1.size());
      src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Source drivers: hold a beat until accepted, optionally idling between beats
  initial begin
    s00_tvalid = 0; s00_tlast = 0; s00_tdata = '0; s00_tstrb = '0;
    forever begin
      @(posedge clk); #1;
      if (acc0 && src_q0.size() != 0) void'(src_q0.pop_front());
      if (src_q0.size() == 0) s00_tvalid = 0;
      else if (!s00_tvalid || acc0) begin
        if (gap_en && $urandom_range(0, 3) == 0) s00_tvalid = 0;
        else begin
          s00_tvalid = 1;
          s00_tdata  = src_q0[0].data;
          s00_tstrb  = src_q0[0].strb;
          s00_tlast  = src_q0[0].last;
        end
      end
    end
  end

  initial begin
    s01_tvalid = 0; s01_tlast = 0; s01_tdata = '0; s01_tstrb = '0;
    forever begin
      @(posedge clk); #1;
      if (acc1 && src_q1.size() != 0) void'(src_q1.pop_front());
      if (src_q1.size() == 0) s01_tvalid = 0;
      else if (!s01_tvalid || acc1) begin
        if (gap_en && $urandom_range(0, 3) == 0) s01_tvalid = 0;
        else begin
          s01_tvalid = 1;
          s01_tdata  = src_q1[0].data;
          s01_tstrb  = src_q1[0].strb;
          s01_tlast  = src_q1[0].last;
        end
      end
    end
  end

  initial begin
    int rc = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (rc % 4 == 0) || (rc % 4 == 3);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares outputs with the packet-level model and pops expected beats
  always @(negedge clk) begin
    cyc++;
    acc0 = s00_tvalid & s00_tready;
    acc1 = s01_tvalid & s01_tready;
    check_output("grant", grant, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
    if (m_owner < 0) begin
      check_output("idle_tvalid", m_tvalid, 0);
      check_output("idle_tready0", s00_tready, 0);
      check_output("idle_tready1", s01_tready, 0);
    end else begin
      check_output("tvalid_pass", m_tvalid, (m_owner == 0) ? s00_tvalid : s01_tvalid);
      check_output("tready0", s00_tready, (m_owner == 0) ? m_tready : 1'b0);
      check_output("tready1", s01_tready, (m_owner == 1) ? m_tready : 1'b0);
    end
    check_output("error_len", error_len, m_err);
    check_output("pkt_count0", pkt_count0, m_cnt0);
    check_output("pkt_count1", pkt_count1, m_cnt1);
    if (m_owner >= 0 && m_tvalid && m_tready) begin
      if ((m_owner == 0 && exp_q0.size() == 0) || (m_owner == 1 && exp_q1.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=%0h required=none", m_tdata);
      end else begin
        mon_e = (m_owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_output("tdata", m_tdata, mon_e.data);
        check_output("tstrb", m_tstrb, mon_e.strb);
        check_output("tlast", m_tlast, mon_e.last);
        acc_cycles.push_back(cyc);
        if (mon_e.last) begin
          if (m_owner == 0) m_cnt0 = m_cnt0 + 16'd1;
          else              m_cnt1 = m_cnt1 + 16'd1;
          if (mon_e.forced) m_err = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end else if (m_owner < 0) begin
      if (s00_tvalid && s01_tvalid) m_owner = (m_last == 1) ? 0 : 1;
      else if (s00_tvalid)          m_owner = 0;
      else if (s01_tvalid)          m_owner = 1;
      if (m_owner >= 0) grant_log.push_back(m_owner + 1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    #1;
    check_output("rst_grant", grant, 0);
    check_output("rst_tvalid", m_tvalid, 0);
    check_output("rst_tready0", s00_tready, 0);
    check_output("rst_tready1", s01_tready, 0);
    check_output("rst_error_len", error_len, 0);
    check_output("rst_counts", {pkt_count1, pkt_count0}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] single 5-beat packet on s00");
    apply_stimulus(0, 5, 32'd2, 0);
    wait_drain(100);
    check_output("single_count0", pkt_count0, 1);
    check_output("single_error", error_len, 0);
    check_output("single_beats", acc_cycles.size(), 5);
    if (acc_cycles.size() == 5) check_output("single_back_to_back", acc_cycles[4] - acc_cycles[0], 4);

    $display("[TB] round-robin contention");
    do_reset();
    apply_stimulus(0, 3, 32'h10, 0);
    apply_stimulus(0, 3, 32'h20, 0);
    apply_stimulus(1, 3, 32'h30, 0);
    apply_stimulus(1, 3, 32'h40, 0);
    wait_drain(200);
    check_output("rr_packets", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check_output("rr_order", grant_log[i], (i % 2 == 0) ? 1 : 2);

    $display("[TB] oversize packet on s01");
    do_reset();
    apply_stimulus(1, 7, 32'h100, 0);
    wait_drain(200);
    check_output("long_count1", pkt_count1, 2);
    check_output("long_error", error_len, 1);
    check_output("long_segments", grant_log.size(), 2);

    $display("[TB] backpressure with competing requester");
    do_reset();
    rdy_mode = 1;
    apply_stimulus(0, 5, 32'h0, 1);
    apply_stimulus(1, 3, 32'h0, 1);
    wait_drain(300);
    rdy_mode = 0;
    check_output("bp_packets", grant_log.size(), 2);
    if (grant_log.size() == 2) check_output("bp_first_owner", grant_log[0], 1);
    check_output("bp_counts", {pkt_count1, pkt_count0}, {16'd1, 16'd1});

    $display("[TB] reset pulse mid-packet");
    do_reset();
    apply_stimulus(0, 5, 32'h50, 0);
    n = 0;
    while (acc_cycles.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check_output("rstpulse_reach_beat3", (n < 50), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("pulse_grant", grant, 0);
    check_output("pulse_tvalid", m_tvalid, 0);
    check_output("pulse_tready0", s00_tready, 0);
    check_output("pulse_tready1", s01_tready, 0);
    check_output("pulse_error", error_len, 0);
    check_output("pulse_counts", {pkt_count1, pkt_count0}, 0);
    #1 rst_n = 1'b1;
    wait_drain(100);
    check_output("after_pulse_count0", pkt_count0, 1);

    $display("[TB] randomized traffic");
    do_reset();
    rdy_mode = 2;
    gap_en   = 1;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)), 32'h0, 1);
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    wait_drain(5000);
    gap_en   = 0;
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32, tdata width of all ports (multiple of 8).
REQ-002 SHALL have parameter NUMBER_OF_WORDS, default 5, maximum beats per packet (range 1..255).
REQ-003 SHALL have port m00_axis_aclk  input  1  single clock for all logic.
REQ-004 SHALL have port m00_axis_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s00_axis_tvalid/tready/tlast  in/out/in  1 each  requester 0 handshake.
REQ-006 SHALL have ports s00_axis_tdata  input  C_AXIS_TDATA_WIDTH, and s00_axis_tstrb  input  C_AXIS_TDATA_WIDTH/8  requester 0 payload.
REQ-007 SHALL have s01_axis_* ports identical in direction and width to REQ-005/006 for requester 1.
REQ-008 SHALL have m00_axis_tvalid/tready/tlast  out/in/out  1 each  shared output handshake.
REQ-009 SHALL have m00_axis_tdata  output  C_AXIS_TDATA_WIDTH, and m00_axis_tstrb  output  C_AXIS_TDATA_WIDTH/8  shared output payload.
REQ-010 SHALL have grant  output  2  one-hot current owner (bit0 = s00, bit1 = s01, 00 = none).
REQ-011 SHALL have error_len  output  1  sticky flag set on a forced packet termination.
REQ-012 SHALL have pkt_count0, pkt_count1  output  16 each  completed packets forwarded per requester.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT0, GRANT1; reset state IDLE.
REQ-014 SHALL in IDLE transition to GRANT0 if only s00_axis_tvalid=1, to GRANT1 if only s01_axis_tvalid=1, and stay in IDLE if neither is valid.
REQ-015 SHALL, when both tvalid are 1 in IDLE, grant the requester not granted last (round-robin); last_grant resets to 1 so s00 wins the first contention.
REQ-016 SHALL take exactly 1 cycle from IDLE to a GRANT state; no beat transfers in IDLE.
REQ-017 SHALL in GRANTx drive m00_axis_tvalid/tdata/tstrb combinationally from s0x, with zero latency.
REQ-018 SHALL drive s0x_axis_tready = m00_axis_tready in GRANTx; the non-granted tready SHALL be 0, and both SHALL be 0 in IDLE.
REQ-019 SHALL drive m00_axis_tvalid=0 in IDLE; tdata/tstrb are don't-care whenever tvalid=0.
REQ-020 SHALL count accepted beats (m00_axis_tvalid & m00_axis_tready) in an 8-bit beat counter, cleared on every packet end.
REQ-021 SHALL drive m00_axis_tlast = s0x_tlast OR (beat counter == NUMBER_OF_WORDS-1).
REQ-022 SHALL, on an accepted beat with m00_axis_tlast=1, return to IDLE on the next edge, update last_grant, and increment the owner's pkt_count (wraps 0xFFFF->0).
REQ-023 SHALL set error_len on an accepted forced-last beat (source tlast=0); remaining source beats are forwarded as a new packet after re-arbitration.
REQ-024 SHALL NOT change grant mid-packet, regardless of the other requester's tvalid or of m00_axis_tready=0 stalls of any length.
REQ-025 SHALL NOT flag a source tlast arriving before NUMBER_OF_WORDS beats (short packets are legal).
REQ-026 SHALL drive grant = 01 in GRANT0, 10 in GRANT1, and 00 in IDLE.

Reset
REQ-027 SHALL, on m00_axis_aresetn=0 at any time including mid-packet, immediately force: state IDLE, grant=00, all tready=0, m00_axis_tvalid=0, beat counter=0, last_grant=1, error_len=0, pkt_count0=pkt_count1=0.
REQ-028 SHALL resume arbitration on the first rising edge after reset deassertion; a packet interrupted by reset is not completed or counted.

Verification
REQ-029 Bench SHALL drive s00 alone with a 5-beat packet (tdata 2..6, tlast on 6), m00_axis_tready=1 -> grant=01 one cycle after tvalid, 5 consecutive output beats, pkt_count0=1, error_len=0.
REQ-030 Bench SHALL assert both requesters with 3-beat packets twice each -> grant order s00, s01, s00, s01, with no interleaved beats and one IDLE cycle between packets.
REQ-031 Bench SHALL send s01 a 7-beat packet with tlast only on beat 7 -> m00_axis_tlast on beat 5, error_len=1, beats 6-7 forwarded as a second packet, pkt_count1=2.
REQ-032 Bench SHALL toggle m00_axis_tready (1,0,0,1,...) during an s00 packet while s01 is valid -> no data loss or duplication, s00_axis_tready mirrors m00_axis_tready, and grant stays 01 until tlast.
REQ-033 Bench SHALL pulse m00_axis_aresetn low for 2 ns during beat 3 of a packet -> all outputs at reset values within the pulse, pkt_count unchanged at 0, and clean re-arbitration afterwards.
